// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sends sync word 11101, then the payload MSB-first.
// A zero is stuffed into the payload so that 11101 appears on the line only as a sync word.
module seq_frame_tx #(
  parameter int DATA_W    = 8,
  parameter int STUFF_RUN = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] datain,
  input  logic              start,
  output logic              ready,
  output logic              dataout,
  output logic              busy,
  output logic              stuff,
  output logic              frame_done
);

  localparam int          CNT_W  = $clog2(DATA_W + 1);
  localparam logic [4:0]  SYNC_W = 5'b11101;
  localparam logic [1:0]  RUN_LIM = 2'(STUFF_RUN);

  // The state names the kind of bit that is on dataout right now.
  typedef enum logic [1:0] {IDLE, SYNC, DATA, STUFF} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] sh_q;
  logic [CNT_W-1:0]  left_q;
  logic [2:0]        sidx_q;
  logic [1:0]        run_q;
  logic              dout_q;
  logic              busy_q;
  logic              stuff_q;
  logic              done_q;

  logic go_payload;
  logic go_stuff;
  logic go_idle;

  // After the bit on the line: a payload bit follows unless the run limit is hit
  // or the payload is exhausted. The last payload bit is never followed by a stuff.
  always_comb begin
    go_payload = 1'b0;
    go_stuff   = 1'b0;
    go_idle    = 1'b0;
    case (state_q)
      SYNC:    go_payload = (sidx_q == 3'd4);
      STUFF:   go_payload = 1'b1;
      DATA: begin
        if (left_q == '0)          go_idle    = 1'b1;
        else if (run_q >= RUN_LIM) go_stuff   = 1'b1;
        else                       go_payload = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      left_q  <= '0;
      sidx_q  <= '0;
      run_q   <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      stuff_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      stuff_q <= 1'b0;
      done_q  <= 1'b0;
      if (go_payload) begin
        state_q <= DATA;
        dout_q  <= sh_q[DATA_W-1];
        sh_q    <= sh_q << 1;
        left_q  <= left_q - 1'b1;
        run_q   <= sh_q[DATA_W-1] ? run_q + 2'd1 : 2'd0;
        done_q  <= (left_q == CNT_W'(1));
        busy_q  <= 1'b1;
      end else if (go_stuff) begin
        state_q <= STUFF;
        dout_q  <= 1'b0;
        stuff_q <= 1'b1;
        run_q   <= 2'd0;
        busy_q  <= 1'b1;
      end else if (go_idle) begin
        state_q <= IDLE;
        dout_q  <= 1'b0;
        busy_q  <= 1'b0;
        run_q   <= 2'd0;
      end else begin
        case (state_q)
          IDLE: begin
            dout_q <= 1'b0;
            busy_q <= 1'b0;
            if (start) begin
              state_q <= SYNC;
              sh_q    <= datain;
              left_q  <= CNT_W'(DATA_W);
              sidx_q  <= 3'd0;
              run_q   <= 2'd0;
              dout_q  <= SYNC_W[4];
              busy_q  <= 1'b1;
            end
          end
          SYNC: begin
            // Run count starts at 1 only once the trailing sync 1 is on the line.
            sidx_q <= sidx_q + 3'd1;
            dout_q <= SYNC_W[3'd3 - sidx_q];
            run_q  <= (sidx_q == 3'd3) ? 2'd1 : 2'd0;
            busy_q <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ready      = (state_q == IDLE);
  assign dataout    = dout_q;
  assign busy       = busy_q;
  assign stuff      = stuff_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: per-cycle line model, 11101 detector and de-stuffer.
module tb_seq_frame_tx;
  localparam int DATA_W    = 8;
  localparam int STUFF_RUN = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] datain = '0;
  logic              ready, dataout, busy, stuff, frame_done;

  seq_frame_tx #(.DATA_W(DATA_W), .STUFF_RUN(STUFF_RUN)) u_dut (
    .clock(clock), .reset(reset), .datain(datain), .start(start),
    .ready(ready), .dataout(dataout), .busy(busy), .stuff(stuff),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic d;
    logic st;
    logic fd;
    logic sync_end;
  } cyc_t;

  cyc_t              exp_q[$];
  logic [DATA_W-1:0] payq[$];
  int npass = 0, ntot = 0;
  int nsync = 0, ndet = 0, nbad = 0, npay = 0, ndone = 0, nframes = 0;

  logic [4:0]        hist = '0;
  bit                col = 0, skip = 0;
  int                drun = 0, nb = 0;
  logic [DATA_W-1:0] word = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Expected line for one frame, built from the framing rules.
  task automatic push_frame(input logic [DATA_W-1:0] p);
    logic [4:0] sw;
    int run;
    sw = 5'b11101;
    for (int i = 4; i >= 0; i--) exp_q.push_back('{d: sw[i], st: 1'b0, fd: 1'b0, sync_end: (i == 0)});
    run = 1;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      exp_q.push_back('{d: p[i], st: 1'b0, fd: (i == 0), sync_end: 1'b0});
      run = p[i] ? run + 1 : 0;
      if (i != 0 && run >= STUFF_RUN) begin
        exp_q.push_back('{d: 1'b0, st: 1'b1, fd: 1'b0, sync_end: 1'b0});
        run = 0;
      end
    end
    payq.push_back(p);
    nframes++;
  endtask

  task automatic step(input logic st, input logic [DATA_W-1:0] di);
    cyc_t cur;
    bit   idle;
    @(negedge clock);
    idle = (exp_q.size() == 0);
    cur  = idle ? cyc_t'(0) : exp_q.pop_front();
    chk("dataout", dataout, cur.d);
    chk("stuff", stuff, cur.st);
    chk("frame_done", frame_done, cur.fd);
    chk("busy", busy, !idle);
    chk("ready", ready, idle);
    if (cur.sync_end) nsync++;
    if (cur.fd) ndone++;
    // De-stuffer working from the line alone.
    if (col) begin
      if (skip) begin
        chk("destuff_zero", dataout, 0);
        skip = 0;
        drun = 0;
      end else begin
        word = (word << 1) | DATA_W'(dataout);
        nb++;
        drun = dataout ? drun + 1 : 0;
        if (nb == DATA_W) begin
          col = 0;
          chk("payload_avail", payq.size() != 0, 1);
          if (payq.size() != 0) chk("payload", word, payq.pop_front());
          npay++;
        end else if (drun >= STUFF_RUN) skip = 1;
      end
    end
    hist = {hist[3:0], dataout};
    if (hist == 5'b11101) begin
      ndet++;
      if (!cur.sync_end) nbad++;
      col = 1; skip = 0; drun = 1; nb = 0; word = '0;
    end
    start  = st;
    datain = di;
    if (idle && st && !reset) push_frame(di);
  endtask

  task automatic model_reset();
    exp_q.delete();
    payq.delete();
    col = 0;
    hist = '0;
  endtask

  initial begin
    // Reset state, with start asserted during reset
    step(1'b1, 8'hAA);
    step(1'b1, 8'hAA);
    step(1'b0, '0);
    reset = 1'b0;

    // Directed frames: 00, FF, B6
    step(1'b1, 8'h00);
    repeat (14) step(1'b0, 8'h55);
    step(1'b1, 8'hFF);
    repeat (18) step(1'b0, '0);
    step(1'b1, 8'hB6);
    repeat (17) step(1'b0, '0);

    // start held high, datain changes while busy
    for (int i = 0; i < 60; i++) step(1'b1, (i % 5 == 2) ? 8'h00 : 8'hFF);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1'b0, '0);
    chk("drain_after_held_start", exp_q.size(), 0);
    step(1'b0, '0);

    // Asynchronous reset on cycle 8 of an FF frame
    step(1'b1, 8'hFF);
    repeat (8) step(1'b0, '0);
    #2 reset = 1'b1;
    #1;
    chk("rst_dataout", dataout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 1);
    chk("rst_stuff", stuff, 0);
    chk("rst_frame_done", frame_done, 0);
    model_reset();
    step(1'b1, 8'hFF);
    step(1'b0, '0);
    reset = 1'b0;
    step(1'b1, 8'h00);
    repeat (14) step(1'b0, '0);

    // Random back-to-back payloads
    begin
      int target;
      target = nframes + 1000;
      for (int i = 0; i < 30000 && nframes < target; i++) step(1'b1, DATA_W'($urandom));
      chk("random_frames_issued", nframes >= target, 1);
    end
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1'b0, '0);
    chk("final_drain", exp_q.size(), 0);
    repeat (3) step(1'b0, '0);

    chk("sync_detections", ndet, nsync);
    chk("stray_detections", nbad, 0);
    chk("payloads_recovered", npay, ndone);
    chk("payload_queue_empty", payq.size(), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
Serial frame transmitter that drives a one-bit line for the 11101 sequence-detector receive path. It accepts a parallel payload word through a valid/ready handshake. It emits the sync word 11101, then the payload MSB-first with zero-bit stuffing. The stuffing guarantees that 11101 never appears on the line except as a frame's sync word. The line idles at 0 between frames.

Parameters:
DATA_W, 8, payload width in bits (legal range 1..32).
STUFF_RUN, 2, maximum run of consecutive 1s allowed after the sync word before a stuff 0 is inserted (legal values 1 or 2 only).

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
datain  input  DATA_W  payload word; sampled only on an accepted start.
start  input  1  request to send a frame (valid).
ready  output  1  block can accept start (ready).
dataout  output  1  serial line, registered.
busy  output  1  frame in progress.
stuff  output  1  high while the bit currently on dataout is a stuff bit.
frame_done  output  1  one-cycle pulse while the last payload bit is on dataout.

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - State goes to IDLE.
  - dataout=0, ready=1, busy=0, stuff=0, frame_done=0.
  - Shift register, bit counter and run counter are cleared.
  - A start sampled while reset is high is ignored.
- States: IDLE, SYNC, DATA, STUFF.
- All outputs are registered, except ready, which is the combinational ~busy decoded from the state register.
- IDLE:
  - dataout=0, busy=0.
  - Accept when start=1 and ready=1 at posedge k: latch datain into the shift register; go to SYNC.
- SYNC:
  - On cycles k+1..k+5, dataout = 1,1,1,0,1 in that order; busy=1.
  - The run counter is held at 0 during SYNC. It is set to 1 on the cycle the final sync 1 is driven.
- DATA:
  - Each cycle drives the next payload bit, MSB first.
  - Run counter: increments on a 1, clears on a 0.
  - After driving bit i: if it was the last payload bit, go to IDLE. Otherwise, if run==STUFF_RUN, go to STUFF. Otherwise stay in DATA.
  - The check applies to the first payload bit too, because the run counter carries the trailing sync 1.
- STUFF:
  - dataout=0 and stuff=1 for exactly one cycle. No payload bit is consumed; run counter clears; return to DATA.
- No stuff bit follows the last payload bit, even if run==STUFF_RUN.
- frame_done=1 only on the cycle the last payload bit is driven.
- The next cycle is IDLE: dataout=0, ready=1.
- Frame length = 5 + DATA_W + (number of stuffs) cycles.
- Minimum gap between frames is one IDLE cycle (dataout=0). Back-to-back starts therefore give exactly one 0 between frames.
- start while busy: ignored; datain is not sampled; no queuing.
- datain changes after acceptance have no effect on the frame in flight.
- Invariant: with STUFF_RUN<=2, no run of three 1s occurs outside a sync word, so 11101 appears on dataout only at frame starts.

Test Plan:
1. DATA_W=8, datain=8'h00, start pulse -> dataout 1110100000000, 13 busy cycles, no stuff, frame_done on cycle 13, dataout=0 and ready=1 on cycle 14.
2. datain=8'hFF -> dataout 11101101101101101 (17 cycles); stuff high on cycles 7,10,13,16; frame_done on cycle 17.
3. datain=8'hB6 -> dataout 1110110011001100 (16 cycles); stuffs at cycles 7,11,15; frame_done on cycle 16; no trailing stuff.
4. start held high continuously with datain=8'hFF -> frames separated by exactly one 0 cycle; start pulses during busy are ignored; a datain change mid-frame does not alter the output.
5. Assert reset on cycle 8 of an 8'hFF frame -> dataout=0, busy=0, ready=1, stuff=0 immediately (asynchronous). After release, a new start with 8'h00 yields the clean 13-cycle frame.
6. 1000 random payloads, back-to-back, feeding the 11101 detector model -> exactly one detection per frame, at the sync word; a de-stuffing model recovers every payload exactly.
